// File: rtl/ucsbece154a_mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM state encodings,
// requester ids, and the arbitration pick.
package ucsbece154a_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_DONE   = 2'b10
  } arb_state_e;

  // Requester ids: m0 is the CPU, m1 is the loader/debug port.
  localparam logic ID_M0 = 1'b0;
  localparam logic ID_M1 = 1'b1;

  // Wait counter width; covers WAIT up to 15.
  localparam int CNT_W = 4;

  // A lone requester wins; on contention the prio bit names the winner.
  function automatic logic arb_pick(input logic req0, input logic req1,
                                    input logic prio);
    if (req0 && req1) return prio;
    return req1 ? ID_M1 : ID_M0;
  endfunction

endpackage

// File: rtl/ucsbece154a_mem_arbiter.sv
// Two-requester memory arbiter. A request is sampled in IDLE, the memory is
// driven for WAIT+1 cycles in ACCESS, and the winner gets a one-cycle done
// pulse in DONE. Priority flips to the other requester after each grant so
// continuous contention alternates.
module ucsbece154a_mem_arbiter #(
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter int WAIT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_done,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_done,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);
  import ucsbece154a_mem_arbiter_pkg::*;

  localparam logic [CNT_W-1:0] WAIT_CNT = CNT_W'(WAIT);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             prio_q, prio_d;
  logic             id_q, id_d;
  logic             we_q, we_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic             pick;

  assign pick = arb_pick(m0_req, m1_req, prio_q);

  // State and datapath registers; reset clears everything including priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      prio_q  <= ID_M0;
      id_q    <= ID_M0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prio_q  <= prio_d;
      id_q    <= id_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state logic: latch the winner in IDLE, count wait states in ACCESS,
  // hand priority to the other requester in DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prio_d  = prio_q;
    id_d    = id_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (m0_req || m1_req) begin
          id_d    = pick;
          we_d    = (pick == ID_M1) ? m1_we    : m0_we;
          addr_d  = (pick == ID_M1) ? m1_addr  : m0_addr;
          wdata_d = (pick == ID_M1) ? m1_wdata : m0_wdata;
          cnt_d   = WAIT_CNT;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == '0) begin
          if (!we_q) rdata_d = mem_rdata;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        prio_d  = ~id_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_en    = (state_q == ST_ACCESS);
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != ST_IDLE);
  assign m0_done   = (state_q == ST_DONE) && (id_q == ID_M0);
  assign m1_done   = (state_q == ST_DONE) && (id_q == ID_M1);
  assign m0_rdata  = rdata_q;
  assign m1_rdata  = rdata_q;

endmodule
